// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, transmit FSM states and scan-code sequence helpers
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_GAP
    } ps2_tx_state_e;

    function automatic logic [1:0] ps2_seq_len(input logic ext, input logic brk);
        return 2'd1 + {1'b0, ext} + {1'b0, brk};
    endfunction

    // Map a sequence index onto the full slot order E0, F0, code, skipping absent prefixes.
    function automatic logic [7:0] ps2_seq_byte(input logic [8:0] code, input logic brk,
                                                input logic [1:0] idx);
        logic [1:0] p;
        p = idx;
        if (!code[8]) p = p + 2'd1;
        if (!brk && p != 2'd0) p = p + 2'd1;
        case (p)
            2'd0:    return PS2_EXT_PREFIX;
            2'd1:    return PS2_BREAK_PREFIX;
            default: return code[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// rtl/ps2_frame_tx.sv - serializes one byte as an 11-bit PS/2 device frame followed by an idle gap
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       frame_done_o
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HMAX = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GPRE = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    ps2_tx_state_e             state_q;
    logic [3:0]                bit_q;
    logic [HW-1:0]             half_q;
    logic [GW-1:0]             gap_q;
    logic [PS2_FRAME_BITS-1:0] shift_q;
    logic                      ps2_clk_q;
    logic                      ps2_data_q;
    logic                      frame_done_q;

    // start_i may arrive in the final gap cycle; the load then overlaps the first BIT_HI cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            bit_q        <= '0;
            half_q       <= '0;
            gap_q        <= '0;
            shift_q      <= '0;
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else if (start_i) begin
            state_q      <= ST_BIT_HI;
            bit_q        <= '0;
            half_q       <= '0;
            gap_q        <= '0;
            shift_q      <= {1'b1, ~^byte_i, byte_i, 1'b0};
            ps2_clk_q    <= 1'b1;
            ps2_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BIT_HI: begin
                    if (half_q == HMAX) begin
                        half_q    <= '0;
                        ps2_clk_q <= 1'b0;
                        state_q   <= ST_BIT_LO;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                ST_BIT_LO: begin
                    if (half_q == HMAX) begin
                        half_q    <= '0;
                        ps2_clk_q <= 1'b1;
                        if (bit_q == 4'(PS2_FRAME_BITS - 1)) begin
                            state_q      <= ST_GAP;
                            ps2_data_q   <= 1'b1;
                            gap_q        <= '0;
                            frame_done_q <= (GAP_CYCLES == 1);
                        end else begin
                            bit_q      <= bit_q + 4'd1;
                            shift_q    <= {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
                            ps2_data_q <= shift_q[1];
                            state_q    <= ST_BIT_HI;
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GMAX) begin
                        state_q      <= ST_IDLE;
                        gap_q        <= '0;
                        frame_done_q <= 1'b0;
                    end else begin
                        gap_q        <= gap_q + 1'b1;
                        frame_done_q <= (gap_q == GPRE);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ps2_clk_o    = ps2_clk_q;
    assign ps2_data_o   = ps2_data_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/ps2_key_transmitter.sv
// rtl/ps2_key_transmitter.sv - latches a make/break key request and sequences its PS/2 scan-code bytes
module ps2_key_transmitter
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    output logic       ps2Clk,
    output logic       ps2Data,
    output logic       busy,
    output logic       done
);

    logic       busy_q;
    logic [8:0] code_q;
    logic       brk_q;
    logic [1:0] idx_q;

    logic       accept;
    logic       frame_done;
    logic       last_byte;
    logic       tx_start;
    logic [7:0] tx_byte;

    // make has priority, so a simultaneous brakee is simply dropped.
    assign accept    = !busy_q && (make || brakee);
    assign last_byte = (idx_q == ps2_seq_len(code_q[8], brk_q) - 2'd1);
    assign tx_start  = accept || (busy_q && frame_done && !last_byte);
    assign tx_byte   = accept ? ps2_seq_byte(keyCode, !make, 2'd0)
                              : ps2_seq_byte(code_q, brk_q, idx_q + 2'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy_q <= 1'b0;
            code_q <= '0;
            brk_q  <= 1'b0;
            idx_q  <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            code_q <= keyCode;
            brk_q  <= !make;
            idx_q  <= '0;
        end else if (busy_q && frame_done) begin
            if (last_byte) begin
                busy_q <= 1'b0;
                code_q <= '0;
                brk_q  <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    ps2_frame_tx #(
        .HALF_PERIOD (HALF_PERIOD),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_frame_tx (
        .clk          (clk),
        .resetN       (resetN),
        .start_i      (tx_start),
        .byte_i       (tx_byte),
        .ps2_clk_o    (ps2Clk),
        .ps2_data_o   (ps2Data),
        .frame_done_o (frame_done)
    );

    assign busy = busy_q;
    assign done = busy_q && frame_done && last_byte;

endmodule
